// File: rtl/apb_mem_slave.sv
// rtl/apb_mem_slave.sv - APB word-addressed memory slave with wait states and write protection
module apb_mem_slave #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 32,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 0,
    parameter int RO_WORDS    = 0
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic [DATA_W-1:0]     pwdata,
    input  logic [DATA_W/8-1:0]   pstrb,
    output logic [DATA_W-1:0]     prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Counter preload so that WAIT lasts exactly WAIT_CYCLES cycles (WAIT_CYCLES-1 down to 0).
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic [DATA_W-1:0]   prdata_q, prdata_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                addr_err;
    logic                ro_hit;
    logic                wr_en;
    logic [IDX_W-1:0]    idx;

    assign idx      = paddr[IDX_W-1:0];
    assign addr_err = (paddr >= ADDR_W'(DEPTH));

    // Protected region only exists when RO_WORDS is non-zero; avoids a constant compare against 0.
    generate
        if (RO_WORDS > 0) begin : g_ro
            assign ro_hit = (paddr < ADDR_W'(RO_WORDS));
        end else begin : g_no_ro
            assign ro_hit = 1'b0;
        end
    endgenerate

    // Next-state and response computation; the response is decided on the edge that enters RESP.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = prdata_q;
        wr_en     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (psel && penable && !pready_q) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (!psel) begin
                    // Master abandoned the transfer: nothing is committed.
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        if (state_d == S_RESP) begin
            pready_d = 1'b1;
            cnt_d    = 4'd0;
            if (addr_err) begin
                pslverr_d = 1'b1;
                if (!pwrite) begin
                    prdata_d = '0;
                end
            end else if (pwrite) begin
                if (ro_hit) begin
                    pslverr_d = 1'b1;
                end else begin
                    wr_en = 1'b1;
                end
            end else begin
                prdata_d = mem_q[idx];
            end
        end
    end

    // FSM state, wait counter and registered response outputs.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    // Memory array: cleared by reset, byte-lane writes only on a committed valid write.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (pstrb[b]) begin
                    mem_q[idx][b*8 +: 8] <= pwdata[b*8 +: 8];
                end
            end
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb/tb_apb_mem_slave.sv - self-checking bench for apb_mem_slave (no-wait and 3-wait instances)
module tb_apb_mem_slave;

    logic        pclk;
    logic        presetn;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [3:0]  pstrb   [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    apb_mem_slave #(.DATA_W(32), .DEPTH(32), .ADDR_W(32), .WAIT_CYCLES(0), .RO_WORDS(4)) dut0 (
        .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]),
        .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0])
    );

    apb_mem_slave #(.DATA_W(32), .DEPTH(32), .ADDR_W(32), .WAIT_CYCLES(3), .RO_WORDS(4)) dut1 (
        .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]),
        .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1])
    );

    // Reference model: memory contents and the outputs each instance must show this cycle.
    logic [31:0] mem_m [2][32];
    logic [31:0] exp_prdata  [2];
    logic        exp_pready  [2];
    logic        exp_pslverr [2];

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  chk_en  = 0;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) mem_m[k][i] = 32'h0;
            exp_prdata[k]  = 32'h0;
            exp_pready[k]  = 1'b0;
            exp_pslverr[k] = 1'b0;
        end
    endtask

    // Cycle-by-cycle output check of both instances against the model.
    always @(negedge pclk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("pready%0d", k),  {31'b0, pready[k]},  {31'b0, exp_pready[k]});
                chk($sformatf("pslverr%0d", k), {31'b0, pslverr[k]}, {31'b0, exp_pslverr[k]});
                chk($sformatf("prdata%0d", k),  prdata[k],           exp_prdata[k]);
            end
        end
    end

    // One APB transfer; entered and left at posedge+1. abort_a>0 drops psel after access edge abort_a.
    task automatic xfer(input int k, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int setup_n, input int abort_a,
                        output logic [31:0] o_rdata, output logic o_err, output int o_rise);
        int          w;
        bit          err;
        bit          aborted;
        logic [31:0] rd;
        w       = wait_of(k);
        err     = (addr >= 32) || (wr && addr < 4);
        rd      = (addr >= 32) ? 32'h0 : mem_m[k][addr[4:0]];
        aborted = 0;
        o_rise  = -1;
        o_rdata = 32'h0;
        o_err   = 1'b0;
        psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr;
        paddr[k] = addr; pwdata[k] = data; pstrb[k] = strb;
        for (int s = 0; s < setup_n; s++) begin
            @(posedge pclk); #1;
        end
        penable[k] = 1'b1;
        for (int n = 1; n <= w + 2; n++) begin
            if (n > 1) begin
                @(posedge pclk); #1;
            end
            if (abort_a > 0 && n == abort_a + 1) begin
                psel[k] = 1'b0; penable[k] = 1'b0;
                aborted = 1;
                break;
            end
            if (n == w + 2) begin
                exp_pready[k]  = 1'b1;
                exp_pslverr[k] = err;
                if (!wr) exp_prdata[k] = err ? 32'h0 : rd;
            end
            if (pready[k] && o_rise < 0) begin
                o_rise  = n;
                o_rdata = prdata[k];
                o_err   = pslverr[k];
            end
        end
        @(posedge pclk); #1;
        if (!aborted && wr && !err) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mem_m[k][addr[4:0]][b*8 +: 8] = data[b*8 +: 8];
        end
        exp_pready[k]  = 1'b0;
        exp_pslverr[k] = 1'b0;
        psel[k] = 1'b0; penable[k] = 1'b0;
    endtask

    logic [31:0] rdata;
    logic        err;
    int          rise;

    initial begin
        presetn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            psel[k] = 0; penable[k] = 0; pwrite[k] = 0;
            paddr[k] = 0; pwdata[k] = 0; pstrb[k] = 0;
        end
        model_clear();
        #3;
        for (int k = 0; k < 2; k++) begin
            chk("rst_pready",  {31'b0, pready[k]},  32'h0);
            chk("rst_pslverr", {31'b0, pslverr[k]}, 32'h0);
            chk("rst_prdata",  prdata[k],           32'h0);
        end
        @(posedge pclk); #3;
        presetn = 1'b1;
        @(posedge pclk); #1;
        chk_en = 1;

        // No-wait instance: full write, read back, byte strobes, errors.
        xfer(0, 1, 5, 32'hDEADBEEF, 4'hF, 1, 0, rdata, err, rise);
        chk("w0_wr_rise", rise, 2);
        chk("w0_wr_err", {31'b0, err}, 32'h0);
        xfer(0, 0, 5, 32'h0, 4'h0, 1, 0, rdata, err, rise);
        chk("w0_rd_rise", rise, 2);
        chk("w0_rd_data", rdata, 32'hDEADBEEF);
        chk("w0_rd_err", {31'b0, err}, 32'h0);
        xfer(0, 1, 5, 32'h11223344, 4'h3, 2, 0, rdata, err, rise);
        xfer(0, 0, 5, 32'h0, 4'h0, 1, 0, rdata, err, rise);
        chk("strb_data", rdata, 32'hDEAD3344);
        xfer(0, 0, 32, 32'h0, 4'hF, 1, 0, rdata, err, rise);
        chk("oob_err", {31'b0, err}, 32'h1);
        chk("oob_data", rdata, 32'h0);
        xfer(0, 1, 2, 32'hFFFFFFFF, 4'hF, 1, 0, rdata, err, rise);
        chk("ro_wr_err", {31'b0, err}, 32'h1);
        xfer(0, 0, 2, 32'h0, 4'h0, 1, 0, rdata, err, rise);
        chk("ro_rd_err", {31'b0, err}, 32'h0);
        chk("ro_rd_data", rdata, 32'h0);
        xfer(0, 1, 6, 32'hCAFEF00D, 4'h0, 1, 0, rdata, err, rise);
        chk("strb0_err", {31'b0, err}, 32'h0);
        xfer(0, 0, 6, 32'h0, 4'h0, 1, 0, rdata, err, rise);
        chk("strb0_data", rdata, 32'h0);

        // Three-wait instance: latency, abort, then reset mid-transfer.
        xfer(1, 1, 9, 32'hA5A5A5A5, 4'hF, 1, 0, rdata, err, rise);
        chk("w3_wr_rise", rise, 5);
        xfer(1, 1, 10, 32'h5A5A5A5A, 4'hF, 1, 1, rdata, err, rise);
        chk("abort_rise", rise, -1);
        xfer(1, 0, 10, 32'h0, 4'h0, 1, 0, rdata, err, rise);
        chk("abort_data", rdata, 32'h0);
        xfer(1, 0, 9, 32'h0, 4'h0, 1, 0, rdata, err, rise);
        chk("w3_rd_rise", rise, 5);
        chk("w3_rd_data", rdata, 32'hA5A5A5A5);

        psel[1] = 1; penable[1] = 0; pwrite[1] = 1;
        paddr[1] = 7; pwdata[1] = 32'h12345678; pstrb[1] = 4'hF;
        @(posedge pclk); #1;
        penable[1] = 1;
        @(posedge pclk); #1;
        @(posedge pclk); #2;
        presetn = 1'b0;
        model_clear();
        #1;
        chk("arst_prdata1",  prdata[1], 32'h0);
        chk("arst_prdata0",  prdata[0], 32'h0);
        chk("arst_pready1",  {31'b0, pready[1]}, 32'h0);
        psel[1] = 0; penable[1] = 0;
        repeat (2) @(posedge pclk);
        #3;
        presetn = 1'b1;
        @(posedge pclk); #1;
        xfer(1, 0, 7, 32'h0, 4'h0, 1, 0, rdata, err, rise);
        chk("post_rst_data", rdata, 32'h0);
        chk("post_rst_rise", rise, 5);
        xfer(0, 0, 5, 32'h0, 4'h0, 1, 0, rdata, err, rise);
        chk("post_rst_mem0", rdata, 32'h0);

        // Randomized traffic on both instances.
        for (int it = 0; it < 200; it++) begin
            int          k;
            int          ab;
            bit          wr;
            logic [31:0] a;
            logic [31:0] d;
            logic [3:0]  s;
            k  = $urandom_range(0, 1);
            wr = $urandom_range(0, 1);
            a  = $urandom_range(0, 35);
            d  = $urandom;
            s  = 4'($urandom_range(0, 15));
            ab = (k == 1 && $urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            xfer(k, wr, a, d, s, $urandom_range(1, 3), ab, rdata, err, rise);
            chk("rnd_rise", rise, (ab > 0) ? -1 : wait_of(k) + 2);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge pclk); #1;
            end
        end

        @(posedge pclk); #1;
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
